// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// The default pattern is stored LSB-aligned, wide enough for the longest pattern.
package seq_det_pkg;

  localparam int PAT_LEN_DEF = 4;
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_DEF   = 8;

  localparam logic [PAT_LEN_MAX-1:0] DEFAULT_PAT_DEF = 16'h0006;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_SHIFT
  } act_e;

  // A pattern load always wins over an incoming data bit.
  function automatic act_e decode_act(input logic load, input logic valid);
    if (load) begin
      return ACT_LOAD;
    end else if (valid) begin
      return ACT_SHIFT;
    end
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Moore serial pattern detector with a runtime-loadable pattern, an overlap mode
// and a saturating match count; seq_out rises the cycle after the final bit.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN     = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = DEFAULT_PAT_DEF[PAT_LEN-1:0],
  parameter int                 CNT_W       = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               count_clr,
  output logic               seq_out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist_q;
  logic [PAT_LEN-1:0] hist_next;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_next;
  logic               hit;
  act_e               act;

  // A match needs a full window of accepted bits, so a partially refilled
  // history can never alias onto the pattern through its zero padding.
  always_comb begin
    act       = decode_act(pat_load, in_valid);
    hist_next = {hist_q[PAT_LEN-2:0], seq_in};
    fill_next = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    hit       = (act == ACT_SHIFT) && (fill_next == FILL_FULL) && (hist_next == pat_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q   <= DEFAULT_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      seq_out <= 1'b0;
    end else begin
      case (act)
        ACT_LOAD: begin
          pat_q   <= pat_in;
          hist_q  <= '0;
          fill_q  <= '0;
          seq_out <= 1'b0;
        end
        ACT_SHIFT: begin
          seq_out <= hit;
          if (hit && !overlap_en) begin
            hist_q <= '0;
            fill_q <= '0;
          end else begin
            hist_q <= hist_next;
            fill_q <= fill_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (hit),
    .clr  (count_clr),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench: a queue-based reference model drives every per-cycle
// comparison, with hand-computed literal checks pinning the model itself.
module tb_seq_detect_prog;

  localparam int PAT_LEN   = 4;
  localparam int CNT_MAX   = 255;
  localparam int SMALL_MAX = 3;

  logic       clock      = 1'b0;
  logic       reset      = 1'b0;
  logic       seq_in     = 1'b0;
  logic       in_valid   = 1'b0;
  logic       overlap_en = 1'b1;
  logic       pat_load   = 1'b0;
  logic [3:0] pat_in     = 4'b0000;
  logic       count_clr  = 1'b0;

  logic       seq_out;
  logic [7:0] match_count;
  logic       seq_out_small;
  logic [1:0] match_count_small;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_pat;
  bit         m_hist[$];
  bit         m_out;
  int         m_cnt;
  int         m_cnt_small;

  seq_detect_prog dut (
    .clock      (clock),
    .reset      (reset),
    .seq_in     (seq_in),
    .in_valid   (in_valid),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .count_clr  (count_clr),
    .seq_out    (seq_out),
    .match_count(match_count)
  );

  seq_detect_prog #(.CNT_W(2)) dut_small (
    .clock      (clock),
    .reset      (reset),
    .seq_in     (seq_in),
    .in_valid   (in_valid),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .count_clr  (count_clr),
    .seq_out    (seq_out_small),
    .match_count(match_count_small)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_pat = 4'b0110;
    m_hist.delete();
    m_out       = 1'b0;
    m_cnt       = 0;
    m_cnt_small = 0;
  endtask

  // The model keeps only the bits accepted since the last restart, oldest first,
  // and declares a match when the last PAT_LEN of them spell the pattern.
  task automatic model_step(input bit v, input bit b, input bit ld,
                            input logic [3:0] p, input bit clr, input bit ovl);
    bit hit;
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_hist.delete();
      m_out = 1'b0;
    end else if (v) begin
      m_hist.push_back(b);
      if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
      if (m_hist.size() == PAT_LEN) begin
        hit = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] != m_pat[PAT_LEN-1-i]) hit = 1'b0;
      end
      if (hit && !ovl) m_hist.delete();
      m_out = hit;
    end
    if (clr) begin
      m_cnt       = 0;
      m_cnt_small = 0;
    end else if (hit) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_cnt_small < SMALL_MAX) m_cnt_small++;
    end
  endtask

  task automatic compare(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, " seq_out"}, int'(seq_out), int'(m_out));
    compare({tag, " match_count"}, int'(match_count), m_cnt);
    compare({tag, " seq_out_small"}, int'(seq_out_small), int'(m_out));
    compare({tag, " match_count_small"}, int'(match_count_small), m_cnt_small);
  endtask

  // Inputs change on the falling edge, the model predicts the rising edge,
  // and outputs are compared at the following falling edge.
  task automatic applyStimulus(input bit v, input bit b, input bit ld,
                               input logic [3:0] p, input bit clr);
    in_valid  = v;
    seq_in    = b;
    pat_load  = ld;
    pat_in    = p;
    count_clr = clr;
    model_step(v, b, ld, p, clr, overlap_en);
    @(negedge clock);
    checkOutput("cycle");
  endtask

  task automatic send_bit(input bit b);
    applyStimulus(1'b1, b, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic load_pat(input logic [3:0] p);
    applyStimulus(1'b0, 1'b0, 1'b1, p, 1'b0);
  endtask

  task automatic clear_count();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare("reset seq_out immediate", int'(seq_out), 0);
    compare("reset match_count immediate", int'(match_count), 0);
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    compare("post-reset seq_out", int'(seq_out), 0);
    compare("post-reset match_count", int'(match_count), 0);
    checkOutput("post-reset");

    // Overlapping: 0110110 matches after bits 4 and 7.
    overlap_en = 1'b1;
    send_seq(16'b0110, 4);
    compare("ovl bit4 seq_out", int'(seq_out), 1);
    send_bit(1'b1);
    compare("ovl bit5 seq_out", int'(seq_out), 0);
    send_seq(16'b10, 2);
    compare("ovl bit7 seq_out", int'(seq_out), 1);
    compare("ovl match_count", int'(match_count), 2);

    clear_count();
    compare("clr match_count", int'(match_count), 0);
    compare("idle hold seq_out", int'(seq_out), 1);

    // Non-overlapping: only the first match of the same stream counts.
    overlap_en = 1'b0;
    load_pat(4'b0110);
    send_seq(16'b0110, 4);
    compare("novl bit4 seq_out", int'(seq_out), 1);
    send_seq(16'b110, 3);
    compare("novl bit7 seq_out", int'(seq_out), 0);
    compare("novl match_count", int'(match_count), 1);

    // Loaded pattern and bit order.
    overlap_en = 1'b1;
    load_pat(4'b0011);
    compare("load seq_out", int'(seq_out), 0);
    send_seq(16'b0011, 4);
    compare("pat0011 seq_out", int'(seq_out), 1);
    send_seq(16'b1100, 4);
    compare("pat0011 reversed seq_out", int'(seq_out), 0);
    compare("pat0011 match_count", int'(match_count), 2);

    // Gap of invalid cycles inside a match, then hold afterwards.
    load_pat(4'b0110);
    send_seq(16'b011, 3);
    repeat (5) idle();
    send_bit(1'b0);
    compare("gap match seq_out", int'(seq_out), 1);
    repeat (3) idle();
    compare("gap hold seq_out", int'(seq_out), 1);
    compare("gap match_count", int'(match_count), 3);

    // Five overlapping hits: the 2-bit counter stops at 3.
    clear_count();
    send_seq(16'b0110110110110110, 16);
    compare("sat match_count", int'(match_count), 5);
    compare("sat match_count_small", int'(match_count_small), 3);
    send_seq(16'b11, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    compare("clr-on-hit seq_out", int'(seq_out), 1);
    compare("clr-on-hit match_count", int'(match_count), 0);
    compare("clr-on-hit match_count_small", int'(match_count_small), 0);

    // Reset mid-stream discards partial history.
    overlap_en = 1'b0;
    load_pat(4'b0110);
    send_seq(16'b0110, 4);
    compare("pre-reset seq_out", int'(seq_out), 1);
    apply_reset();
    send_seq(16'b011, 3);
    apply_reset();
    send_bit(1'b0);
    compare("after-reset seq_out", int'(seq_out), 0);
    compare("after-reset match_count", int'(match_count), 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) < 3) begin
        apply_reset();
      end else begin
        if ($urandom_range(0, 49) == 0) overlap_en = ~overlap_en;
        applyStimulus($urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 59) == 0,
                      4'($urandom_range(0, 15)),
                      $urandom_range(0, 39) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
